// File: rtl/soc_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : soc_interconnect
// Brief    : Single-master to multi-slave bus bridge. Decodes the top address
//            byte to a slave and steers one-cycle strobes to it. It supports
//            fixed 1-cycle slaves and handshake slaves with a timeout. It
//            flags unmapped or timed-out transfers and logs errors.
// Revision : 1.0 - initial release
// ============================================================================
module soc_interconnect #(
    parameter int unsigned                NUM_SLAVES     = 8,
    parameter int unsigned                DATA_WIDTH     = 32,
    // Slots are listed left to right: the leftmost byte is slave 0's tag.
    parameter logic [NUM_SLAVES*8-1:0]    SLAVE_TAGS     = {8'h00, 8'h02, 8'h03, 8'h04,
                                                            8'h05, 8'h06, 8'h0F, 8'h07},
    parameter logic [NUM_SLAVES-1:0]      FIXED_LAT_MASK = '1,
    parameter int unsigned                TIMEOUT_CYCLES = 255
) (
    input  logic                             clk,
    input  logic                             reset,
    // Master side
    input  logic [31:0]                      m_addr_i,
    input  logic [DATA_WIDTH-1:0]            m_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]          m_wmask_i,
    input  logic                             m_wstrb_i,
    input  logic                             m_rstrb_i,
    output logic [DATA_WIDTH-1:0]            m_rdata_o,
    output logic                             m_done_o,
    output logic                             m_err_o,
    // Slave side
    output logic [31:0]                      s_addr_o,
    output logic [DATA_WIDTH-1:0]            s_wdata_o,
    output logic [DATA_WIDTH/8-1:0]          s_wmask_o,
    output logic [NUM_SLAVES-1:0]            s_rstrb_o,
    output logic [NUM_SLAVES-1:0]            s_wstrb_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
    input  logic [NUM_SLAVES-1:0]            s_done_i,
    // Error log
    output logic [7:0]                       err_count_o,
    output logic [31:0]                      err_addr_o
);

    localparam int unsigned IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [31:0]            addr_q;
    logic                   err_q;
    logic [15:0]            cnt_q;
    logic [7:0]             err_count_q;
    logic [31:0]            err_addr_q;

    logic [7:0]             w_tag       [NUM_SLAVES];
    logic [DATA_WIDTH-1:0]  w_slot_data [NUM_SLAVES];
    logic                   w_dec_hit;
    logic [IDX_W-1:0]       w_dec_idx;
    logic                   w_start;
    logic [DATA_WIDTH-1:0]  w_sel_rdata;
    logic                   w_sel_done;
    logic                   w_timeout;

    // Unpack the per-slave tag and read-data slots into arrays.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slots
            assign w_tag[gi]       = SLAVE_TAGS[(NUM_SLAVES-1-gi)*8 +: 8];
            assign w_slot_data[gi] = s_rdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Address decode: the lowest-numbered slave whose tag matches wins.
    always_comb begin
        w_dec_hit = 1'b0;
        w_dec_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (!w_dec_hit && (w_tag[i] == m_addr_i[31:24])) begin
                w_dec_hit = 1'b1;
                w_dec_idx = IDX_W'(i);
            end
        end
    end

    assign w_start     = (state_q == ST_IDLE) && (m_rstrb_i || m_wstrb_i);
    assign w_sel_rdata = w_slot_data[idx_q];
    assign w_sel_done  = s_done_i[idx_q];
    // A completion arriving in the final allowed cycle still counts as success.
    assign w_timeout   = (state_q == ST_WAIT) && !w_sel_done && (cnt_q == C_TIMEOUT);

    // Broadcast master signals to every slave.
    assign s_addr_o  = m_addr_i;
    assign s_wdata_o = m_wdata_i;
    assign s_wmask_o = m_wmask_i;

    // Per-slave strobes: only the decoded slave, only in IDLE. Write wins over read.
    always_comb begin
        s_rstrb_o = '0;
        s_wstrb_o = '0;
        if (!reset && (state_q == ST_IDLE) && w_dec_hit) begin
            s_wstrb_o[w_dec_idx] = m_wstrb_i;
            s_rstrb_o[w_dec_idx] = m_rstrb_i && !m_wstrb_i;
        end
    end

    // Master response: DONE reports the registered outcome, WAIT passes the
    // selected slave's handshake through or reports a timeout.
    always_comb begin
        m_done_o  = 1'b0;
        m_err_o   = 1'b0;
        m_rdata_o = w_sel_rdata;
        case (state_q)
            ST_DONE: begin
                m_done_o = 1'b1;
                m_err_o  = err_q;
                if (err_q) begin
                    m_rdata_o = '1;
                end
            end
            ST_WAIT: begin
                if (w_sel_done) begin
                    m_done_o = 1'b1;
                end else if (w_timeout) begin
                    m_done_o  = 1'b1;
                    m_err_o   = 1'b1;
                    m_rdata_o = '1;
                end
            end
            default: ;
        endcase
    end

    // Transfer state machine with registered slave index, address and timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_start) begin
                        idx_q  <= w_dec_idx;
                        addr_q <= m_addr_i;
                        if (!w_dec_hit) begin
                            err_q   <= 1'b1;
                            state_q <= ST_DONE;
                        end else if (FIXED_LAT_MASK[w_dec_idx]) begin
                            err_q   <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            err_q   <= 1'b0;
                            cnt_q   <= 16'd1;
                            state_q <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_sel_done || w_timeout) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_DONE: begin
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    err_q   <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Error log: saturating count and the address of the most recent failure.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else if (m_err_o) begin
            if (err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
            err_addr_q <= addr_q;
        end
    end

    assign err_count_o = err_count_q;
    assign err_addr_o  = err_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_soc_interconnect.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_interconnect
// Brief    : Scoreboard bench for soc_interconnect. Expected completions are
//            queued when a transfer is launched and matched when m_done fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_interconnect;

    localparam int NS = 8;
    localparam int DW = 32;

    logic            clk;
    logic            reset;
    logic [31:0]     m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wmask;
    logic            m_wstrb;
    logic            m_rstrb;
    logic [DW-1:0]   m_rdata;
    logic            m_done;
    logic            m_err;
    logic [31:0]     s_addr;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wmask;
    logic [NS-1:0]   s_rstrb;
    logic [NS-1:0]   s_wstrb;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0]   s_done;
    logic [7:0]      err_count;
    logic [31:0]     err_addr;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc   = 0;

    soc_interconnect #(
        .NUM_SLAVES     (NS),
        .DATA_WIDTH     (DW),
        .SLAVE_TAGS     (64'h00_02_03_04_05_06_0F_07),
        .FIXED_LAT_MASK (8'b1111_1101),
        .TIMEOUT_CYCLES (4)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .m_addr_i    (m_addr),
        .m_wdata_i   (m_wdata),
        .m_wmask_i   (m_wmask),
        .m_wstrb_i   (m_wstrb),
        .m_rstrb_i   (m_rstrb),
        .m_rdata_o   (m_rdata),
        .m_done_o    (m_done),
        .m_err_o     (m_err),
        .s_addr_o    (s_addr),
        .s_wdata_o   (s_wdata),
        .s_wmask_o   (s_wmask),
        .s_rstrb_o   (s_rstrb),
        .s_wstrb_o   (s_wstrb),
        .s_rdata_i   (s_rdata),
        .s_done_i    (s_done),
        .err_count_o (err_count),
        .err_addr_o  (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] slot_val(input int i);
        return 32'h5A00_0000 + 32'(i) * 32'h0000_0111;
    endfunction

    task automatic push(input logic [31:0] rdata, input logic err, input int at_cyc);
        sb_t e;
        e.rdata = rdata;
        e.err   = err;
        e.cyc   = at_cyc;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a transfer that completes in the following cycle (fixed slave or unmapped).
    task automatic xfer_fixed(input logic [31:0] addr, input logic rd, input logic wr,
                              input int slot, input logic [7:0] exp_rs, input logic [7:0] exp_ws);
        m_addr  = addr;
        m_rstrb = rd;
        m_wstrb = wr;
        m_wdata = $urandom;
        m_wmask = 4'(($urandom_range(0, 15)));
        push((slot < 0) ? 32'hFFFF_FFFF : slot_val(slot), (slot < 0), cyc + 1);
        #2;
        check_eq("s_rstrb", s_rstrb, exp_rs);
        check_eq("s_wstrb", s_wstrb, exp_ws);
        check_eq("s_wdata", s_wdata, m_wdata);
        tick();
        m_rstrb = 1'b0;
        m_wstrb = 1'b0;
        tick();
    endtask

    // Completion monitor: every m_done must match the oldest expected entry.
    always @(negedge clk) begin : mon
        sb_t e;
        if (m_done) begin
            if (sb.size() == 0) begin
                check_eq("stray_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check_eq("done_cycle", 64'(cyc), 64'(e.cyc));
                check_eq("m_rdata", m_rdata, e.rdata);
                check_eq("m_err", m_err, e.err);
            end
        end else begin
            check_eq("err_without_done", m_err, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        m_addr  = 32'h0500_0010;
        m_wdata = '0;
        m_wmask = '0;
        m_wstrb = 1'b0;
        m_rstrb = 1'b1;
        s_done  = '0;
        for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = slot_val(i);

        // Reset state, with a master strobe held to confirm strobes stay low.
        tick();
        tick();
        #2;
        check_eq("rst_m_done", m_done, 0);
        check_eq("rst_m_err", m_err, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_err_addr", err_addr, 0);
        check_eq("rst_s_rstrb", s_rstrb, 0);
        check_eq("rst_s_wstrb", s_wstrb, 0);
        tick();
        m_rstrb = 1'b0;
        reset   = 1'b0;
        tick();

        // Fixed-latency reads and writes, back to back at one per two cycles.
        xfer_fixed(32'h0500_0010, 1, 0, 4, 8'h10, 8'h00);
        check_eq("s_addr", s_addr, 32'h0500_0010);
        xfer_fixed(32'h0000_0004, 1, 0, 0, 8'h01, 8'h00);
        xfer_fixed(32'h0300_0000, 0, 1, 2, 8'h00, 8'h04);
        xfer_fixed(32'h0400_0000, 1, 0, 3, 8'h08, 8'h00);
        xfer_fixed(32'h0600_0000, 1, 0, 5, 8'h20, 8'h00);
        xfer_fixed(32'h07AB_CDEF, 1, 0, 7, 8'h80, 8'h00);
        // Both strobes: treated as a write.
        xfer_fixed(32'h0F00_0000, 1, 1, 6, 8'h00, 8'h40);

        // Strobe held into DONE must be ignored.
        m_addr  = 32'h0400_0000;
        m_rstrb = 1'b1;
        push(slot_val(3), 1'b0, cyc + 1);
        tick();
        m_addr = 32'h0600_0000;
        #2;
        check_eq("strobe_in_done", s_rstrb, 0);
        tick();
        m_rstrb = 1'b0;
        tick();

        // Handshake slave: completes 3 cycles after the strobe.
        m_addr  = 32'h0220_0000;
        m_rstrb = 1'b1;
        #2;
        check_eq("hs_s_rstrb", s_rstrb, 8'h02);
        tick();
        m_rstrb = 1'b0;
        s_done  = 8'h08;            // stray completion from another slave
        tick();
        s_done  = '0;
        m_addr  = 32'h0500_0000;
        m_wstrb = 1'b1;             // new strobe during WAIT
        #2;
        check_eq("wait_s_wstrb", s_wstrb, 0);
        check_eq("wait_s_rstrb", s_rstrb, 0);
        tick();
        m_wstrb = 1'b0;
        s_done  = 8'h02;
        push(slot_val(1), 1'b0, cyc);
        tick();
        s_done = '0;
        tick();
        check_eq("hs_err_count", err_count, 0);

        // Handshake timeout on the fourth WAIT cycle.
        m_addr  = 32'h0220_0000;
        m_rstrb = 1'b1;
        push(32'hFFFF_FFFF, 1'b1, cyc + 4);
        tick();
        m_rstrb = 1'b0;
        tick();
        tick();
        tick();
        tick();
        #2;
        check_eq("to_err_count", err_count, 1);
        check_eq("to_err_addr", err_addr, 32'h0220_0000);
        s_done = 8'h02;             // late completion, must be ignored
        tick();
        s_done = '0;
        tick();

        // Reset asserted mid-WAIT aborts the transfer silently.
        m_addr  = 32'h0220_0000;
        m_rstrb = 1'b1;
        tick();
        m_rstrb = 1'b0;
        tick();
        reset = 1'b1;
        #2;
        check_eq("wrst_m_done", m_done, 0);
        check_eq("wrst_m_err", m_err, 0);
        check_eq("wrst_err_count", err_count, 0);
        check_eq("wrst_err_addr", err_addr, 0);
        check_eq("wrst_s_rstrb", s_rstrb, 0);
        tick();
        reset  = 1'b0;
        s_done = 8'h02;
        tick();
        s_done = '0;
        tick();
        xfer_fixed(32'h0500_0020, 1, 0, 4, 8'h10, 8'h00);

        // Unmapped writes: error pulse each time, counter saturates.
        for (int k = 0; k < 300; k++) begin
            xfer_fixed(32'hA000_0000, 0, 1, -1, 8'h00, 8'h00);
            if (k == 0) check_eq("unm_err_count_1", err_count, 1);
        end
        check_eq("sat_err_count", err_count, 8'd255);
        check_eq("sat_err_addr", err_addr, 32'hA000_0000);

        tick();
        tick();
        check_eq("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
